// File: rtl/cpu_dbg_ctrl_pkg.sv
// Shared definitions for the RV32 debug controller: command opcodes, FSM
// state encodings, halt cause codes, the latched-command struct and an
// address zero-extension helper.
package cpu_dbg_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int RF_IDX_W = 5;

  typedef enum logic [2:0] {
    OP_HALT  = 3'd0,
    OP_RUN   = 3'd1,
    OP_STEP  = 3'd2,
    OP_WIM   = 3'd3,
    OP_WDM   = 3'd4,
    OP_RDM   = 3'd5,
    OP_RRF   = 3'd6,
    OP_SETBP = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_CMD  = 2'd0,
    C_BP   = 2'd1,
    C_DONE = 2'd2,
    C_STEP = 2'd3
  } cause_e;

  // Memory/RF access captured at accept time; the bus is not ready while the
  // access is in flight, so the command must be held locally.
  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  // Keep the low w bits of an address, clear the rest (w < DATA_W).
  function automatic logic [DATA_W-1:0] zext_addr(input logic [DATA_W-1:0] a,
                                                  input int unsigned w);
    return a & ((32'h1 << w) - 32'h1);
  endfunction

endpackage

// File: rtl/cpu_dbg_ctrl_if.sv
// Debug command/response channel.
//  cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data : host -> controller command
//  rsp_valid/rsp_data                           : controller -> host read data
// master = debug host, slave = controller.
interface cpu_dbg_ctrl_if;
  import cpu_dbg_ctrl_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  op_e         cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/cpu_dbg_ctrl_step_cnt.sv
// Loadable down-counter for single/multi-step execution.
//  clk, rst  : clock, async active-high reset
//  load      : load load_val (a zero count loads 1, so STEP 0 runs once)
//  load_val  : requested step count
//  dec       : decrement by one (saturates at zero)
//  zero, one : count == 0 / count == 1
module cpu_dbg_ctrl_step_cnt #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  input  logic              dec,
  output logic              zero,
  output logic              one
);
  logic [STEP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= (load_val == '0) ? STEP_W'(1) : load_val;
    else if (dec && !zero)
      cnt <= cnt - STEP_W'(1);
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == STEP_W'(1));
endmodule

// File: rtl/cpu_dbg_ctrl.sv
// Run/halt/step controller and debug memory-port mux for a single-cycle RV32.
//  clk, rstn        : core clock; rstn is an async ACTIVE-HIGH reset
//  bus (slave)      : debug command/response channel
//  pc, done         : core PC and self-loop indication (pc == npc)
//  cpu_en           : core state-update enable
//  dbg              : 1 = IM/DM/RF addressed by the debug port
//  dbg_addr/dbg_din : debug address and write data
//  we_im, we_dm     : debug write enables
//  dout_dm, dout_rf : async read data from DM and RF port 0
//  state_o, cause   : current FSM state, last halt cause
//  run_cycles       : count of cpu_en cycles (wraps)
module cpu_dbg_ctrl
  import cpu_dbg_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int STEP_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  cpu_dbg_ctrl_if.slave       bus,
  input  logic [31:0]         pc,
  input  logic                done,
  output logic                cpu_en,
  output logic                dbg,
  output logic [31:0]         dbg_addr,
  output logic [31:0]         dbg_din,
  output logic                we_im,
  output logic                we_dm,
  input  logic [31:0]         dout_dm,
  input  logic [31:0]         dout_rf,
  output logic [2:0]          state_o,
  output logic [1:0]          cause,
  output logic [31:0]         run_cycles
);

  state_e      state, state_n;
  cause_e      cause_q, cause_n;
  acc_t        acc;
  logic        first, first_n;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] rsp_data_q;
  logic        ready;
  logic        st_load, st_zero, st_one;
  logic        bp_hit, halt_cmd;

  cpu_dbg_ctrl_step_cnt #(.STEP_W(STEP_W)) u_step_cnt (
    .clk      (clk),
    .rst      (rstn),
    .load     (st_load),
    .load_val (bus.cmd_data[STEP_W-1:0]),
    .dec      (cpu_en && state == S_STEP),
    .zero     (st_zero),
    .one      (st_one)
  );

  // first masks the breakpoint on the cycle after resume, so a RUN issued
  // while sitting on the breakpoint PC executes that instruction.
  assign bp_hit   = bp_en && (pc == bp_addr) && !first;
  assign halt_cmd = bus.cmd_valid && (bus.cmd_op == OP_HALT);

  always_comb begin
    state_n = state;
    cause_n = cause_q;
    first_n = 1'b0;
    ready   = 1'b0;
    cpu_en  = 1'b0;
    dbg     = 1'b1;
    we_im   = 1'b0;
    we_dm   = 1'b0;
    st_load = 1'b0;
    case (state)
      S_HALT: begin
        ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_RUN:          begin state_n = S_RUN; first_n = 1'b1; end
            OP_STEP:         begin state_n = S_STEP; first_n = 1'b1; st_load = 1'b1; end
            OP_WIM, OP_WDM:  state_n = S_WRITE;
            OP_RDM, OP_RRF:  state_n = S_READ;
            default:         state_n = S_HALT;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        // Any non-HALT op is accepted and dropped while running.
        ready  = 1'b1;
        dbg    = 1'b0;
        cpu_en = 1'b1;
        if (halt_cmd) begin
          cpu_en = 1'b0; state_n = S_HALT; cause_n = C_CMD;
        end else if (bp_hit) begin
          cpu_en = 1'b0; state_n = S_HALT; cause_n = C_BP;
        end else if (done) begin
          cpu_en = 1'b0; state_n = S_HALT; cause_n = C_DONE;
        end else if (state == S_STEP && (st_one || st_zero)) begin
          // Last step retires; an empty counter should never be seen here,
          // but if it is, stop without executing.
          cpu_en = st_one; state_n = S_HALT; cause_n = C_STEP;
        end
      end
      S_WRITE: begin
        we_im   = (acc.op == OP_WIM);
        we_dm   = (acc.op == OP_WDM);
        state_n = S_HALT;
      end
      S_READ:  state_n = S_RESP;
      S_RESP:  state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state      <= S_HALT;
      cause_q    <= C_CMD;
      first      <= 1'b0;
      bp_en      <= 1'b0;
      bp_addr    <= '0;
      acc        <= '{op: OP_HALT, addr: '0, data: '0};
      rsp_data_q <= '0;
      run_cycles <= '0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      first   <= first_n;
      if (cpu_en)
        run_cycles <= run_cycles + 32'd1;
      if (state == S_HALT && bus.cmd_valid) begin
        case (bus.cmd_op)
          OP_WIM, OP_WDM, OP_RDM:
            acc <= '{op: bus.cmd_op, addr: zext_addr(bus.cmd_addr, ADDR_W), data: bus.cmd_data};
          OP_RRF:
            acc <= '{op: bus.cmd_op, addr: zext_addr(bus.cmd_addr, RF_IDX_W), data: bus.cmd_data};
          OP_SETBP: begin
            bp_addr <= bus.cmd_addr;
            bp_en   <= bus.cmd_data[0];
          end
          default: ;
        endcase
      end
      // Address has been stable for the whole READ cycle; sample async RAM.
      if (state == S_READ)
        rsp_data_q <= (acc.op == OP_RDM) ? dout_dm : dout_rf;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign dbg_addr      = acc.addr;
  assign dbg_din       = acc.data;
  assign state_o       = state;
  assign cause         = cause_q;

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
module tb_cpu_dbg_ctrl;
  import cpu_dbg_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cpu_dbg_ctrl_if bus();

  logic [31:0] pc, dbg_addr, dbg_din, dout_dm, dout_rf, run_cycles;
  logic        done, cpu_en, dbg, we_im, we_dm;
  logic [2:0]  state_o;
  logic [1:0]  cause;

  logic [31:0] im [0:1023];
  logic [31:0] dm [0:1023];
  logic [31:0] rf [0:31];
  logic [31:0] done_pc, pc_ld_val;
  logic        pc_ld;
  int          we_im_cnt = 0;
  int          en_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          n0;

  cpu_dbg_ctrl #(.ADDR_W(10), .STEP_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .pc         (pc),
    .done       (done),
    .cpu_en     (cpu_en),
    .dbg        (dbg),
    .dbg_addr   (dbg_addr),
    .dbg_din    (dbg_din),
    .we_im      (we_im),
    .we_dm      (we_dm),
    .dout_dm    (dout_dm),
    .dout_rf    (dout_rf),
    .state_o    (state_o),
    .cause      (cause),
    .run_cycles (run_cycles)
  );

  // Minimal core + memory model
  assign done    = (pc == done_pc);
  assign dout_dm = dm[dbg_addr[9:0]];
  assign dout_rf = rf[dbg_addr[4:0]];

  always @(posedge clk) begin
    if (we_im) begin im[dbg_addr[9:0]] <= dbg_din; we_im_cnt++; end
    if (we_dm) dm[dbg_addr[9:0]] <= dbg_din;
    if (cpu_en) en_cnt++;
    if (pc_ld) pc <= pc_ld_val;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input op_e op, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_data = d; bus.cmd_valid = 1'b1;
    #1;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
    chk("cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 40 && state_o != 3'd0; i++) tick();
    chk("halt_timeout", {29'd0, state_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_HALT; bus.cmd_addr = '0; bus.cmd_data = '0;
    pc_ld = 1'b1; pc_ld_val = 32'd0; done_pc = 32'hFFFF_FFFF;
    rf[7] = 32'h1234_5678;
    tick(); tick(); tick();

    // Reset values
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_dbg", {31'd0, dbg}, 32'd1);
    chk("rst_we", {30'd0, we_im, we_dm}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);

    rstn = 1'b0;
    tick();
    pc_ld = 1'b0;

    // IM writes: one-cycle we_im each
    send(OP_WIM, 32'd0, 32'h0000_0013);
    chk("wim0_we", {31'd0, we_im}, 32'd1);
    chk("wim0_addr", dbg_addr, 32'd0);
    chk("wim0_din", dbg_din, 32'h13);
    chk("wim0_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    chk("wim0_we_off", {31'd0, we_im}, 32'd0);
    chk("wim0_state", {29'd0, state_o}, 32'd0);
    send(OP_WIM, 32'd1, 32'h0000_006F);
    chk("wim1_addr", dbg_addr, 32'd1);
    tick();
    chk("wim_we_cnt", we_im_cnt, 32'd2);
    chk("im0", im[0], 32'h13);
    chk("im1", im[1], 32'h6F);

    // RUN until done at pc=4
    done_pc = 32'd4;
    send(OP_RUN, 32'd0, 32'd0);
    chk("run_state", {29'd0, state_o}, 32'd1);
    chk("run_en", {31'd0, cpu_en}, 32'd1);
    chk("run_dbg", {31'd0, dbg}, 32'd0);
    tick();
    chk("done_pc", pc, 32'd4);
    chk("done_en", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("done_state", {29'd0, state_o}, 32'd0);
    chk("done_cause", {30'd0, cause}, 32'd2);
    chk("done_cycles", run_cycles, 32'd1);

    // Breakpoint at 0x8 on straight-line code
    done_pc = 32'hFFFF_FFFF;
    pc_ld = 1'b1; pc_ld_val = 32'd0; tick(); pc_ld = 1'b0;
    send(OP_SETBP, 32'h8, 32'd1);
    chk("setbp_state", {29'd0, state_o}, 32'd0);
    send(OP_RUN, 32'd0, 32'd0);
    tick(); tick();
    chk("bp_pc", pc, 32'd8);
    chk("bp_en", {31'd0, cpu_en}, 32'd0);
    tick();
    chk("bp_state", {29'd0, state_o}, 32'd0);
    chk("bp_cause", {30'd0, cause}, 32'd1);
    chk("bp_pc_hold", pc, 32'd8);

    // Resume from breakpoint makes progress, then HALT command
    send(OP_RUN, 32'd0, 32'd0);
    chk("resume_en", {31'd0, cpu_en}, 32'd1);
    tick();
    chk("resume_pc", pc, 32'd12);
    bus.cmd_op = OP_HALT; bus.cmd_valid = 1'b1; #1;
    chk("haltcmd_en", {31'd0, cpu_en}, 32'd0);
    tick();
    bus.cmd_valid = 1'b0; #1;
    chk("haltcmd_state", {29'd0, state_o}, 32'd0);
    chk("haltcmd_cause", {30'd0, cause}, 32'd0);
    chk("haltcmd_pc", pc, 32'd12);
    chk("haltcmd_cycles", run_cycles, 32'd4);

    // STEP 3 and STEP 0
    n0 = en_cnt;
    send(OP_STEP, 32'd0, 32'd3);
    wait_halt();
    chk("step3_cnt", en_cnt - n0, 32'd3);
    chk("step3_cause", {30'd0, cause}, 32'd3);
    chk("step3_pc", pc, 32'd24);
    n0 = en_cnt;
    send(OP_STEP, 32'd0, 32'd0);
    wait_halt();
    chk("step0_cnt", en_cnt - n0, 32'd1);
    chk("step0_pc", pc, 32'd28);

    // DM write and read-back (upper address bits dropped)
    send(OP_WDM, 32'd5, 32'hDEAD_BEEF);
    chk("wdm_we", {31'd0, we_dm}, 32'd1);
    chk("wdm_addr", dbg_addr, 32'd5);
    tick();
    send(OP_RDM, 32'h0000_0405, 32'd0);
    chk("rdm_state", {29'd0, state_o}, 32'd4);
    chk("rdm_addr", dbg_addr, 32'd5);
    chk("rdm_vld0", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("rdm_vld1", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rdm_data", bus.rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("rdm_vld2", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rdm_hold", bus.rsp_data, 32'hDEAD_BEEF);
    chk("rdm_state2", {29'd0, state_o}, 32'd0);

    // RF read (index from addr[4:0])
    send(OP_RRF, 32'h0000_0027, 32'd0);
    chk("rrf_addr", dbg_addr, 32'd7);
    tick();
    chk("rrf_vld", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rrf_data", bus.rsp_data, 32'h1234_5678);
    tick();

    // Reset asserted during READ
    send(OP_RDM, 32'd5, 32'd0);
    chk("rstrd_state0", {29'd0, state_o}, 32'd4);
    rstn = 1'b1; #1;
    chk("rstrd_state", {29'd0, state_o}, 32'd0);
    chk("rstrd_en", {31'd0, cpu_en}, 32'd0);
    chk("rstrd_cycles", run_cycles, 32'd0);
    chk("rstrd_vld", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    rstn = 1'b0;
    tick();
    chk("rstrd_vld2", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rstrd_data", bus.rsp_data, 32'd0);
    chk("rstrd_state2", {29'd0, state_o}, 32'd0);
    chk("rstrd_dm_kept", dm[5], 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
